opcode_issue_sequencer: RTL and testbench
=========================================

# opcode_issue_sequencer

Instruction issue front-end that buffers 4-bit opcodes from the fetch side and drives the `opcode`/`valid` pair consumed by `high_perf_control_unit`. It issues one instruction per unstalled cycle. After every BRANCH or JUMP it inserts a programmable number of bubble (NOP, valid=0) cycles. It supports downstream stall and a pipeline flush.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- BUBBLES, 2, invalid cycles inserted after an issued BRANCH (1000) or JUMP (1001); range 0..7
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_opcode  in  4  opcode offered by fetch
- in_valid  in  1  in_opcode is valid
- in_ready  out  1  sequencer accepts; push occurs on a clock edge where in_valid && in_ready
- stall  in  1  downstream hold; freezes issue state
- flush  in  1  discard queue and pending bubbles
- opcode  out  4  registered opcode to the control unit
- valid  out  1  registered valid to the control unit
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- busy  out  1  FIFO non-empty or bubble in progress

## Operation
- Reset (rst=1, asynchronous) forces:
  - opcode=0000, valid=0, count=0, busy=0
  - state IDLE, bubble counter 0, FIFO pointers 0
  - in_ready=0 while rst is high and 1 in the first cycle after release
- in_ready = (count < DEPTH) && !flush && !rst. No push at full, even when a pop happens in the same cycle.
- States:
  - IDLE: FIFO empty, no bubble
  - ISSUE: FIFO non-empty
  - BUBBLE: bubble counter > 0
- On each edge with stall=0 and flush=0:
  - ISSUE/IDLE with FIFO non-empty: pop the head into opcode and set valid=1.
    - If the popped opcode is 1000 or 1001 and BUBBLES>0: load counter=BUBBLES and go to BUBBLE.
    - Otherwise go to ISSUE, or to IDLE if the FIFO becomes empty.
  - ISSUE/IDLE with FIFO empty: opcode=0000, valid=0.
  - BUBBLE: opcode=0000, valid=0, counter decrements. When the counter reaches 0, the next edge resumes ISSUE/IDLE. No pop occurs during BUBBLE.
- stall=1: opcode, valid, FIFO read pointer, state and counter all hold. Pushes are still accepted while not full.
- flush=1 (highest priority below rst):
  - FIFO emptied (count=0), same-cycle push dropped (in_ready=0)
  - counter cleared, state IDLE
  - opcode=0000, valid=0 on that edge, regardless of stall
- Opcodes 1100–1111 are issued unmodified; the control unit treats them as NOP.
- count updates by +1 on push, −1 on pop, unchanged on simultaneous push+pop. Pointers wrap modulo DEPTH.

## Timing
- Push-to-issue latency: 1 cycle. An opcode pushed at edge N into an empty, idle, unstalled sequencer appears on opcode/valid after edge N+1.
- Throughput: 1 opcode/cycle with no stall and no branch/jump.
- A BRANCH/JUMP issued at edge N is followed by valid=0 after edges N+1..N+BUBBLES. The next opcode appears after edge N+BUBBLES+1, with stalled edges not counted.
- All outputs except in_ready are registered. in_ready is combinational from the count register, flush and rst.
- Reset assertion mid-stream clears everything immediately, without waiting for a clock. Queued opcodes are lost.

## Test plan
- Reset: push 3 opcodes, assert rst asynchronously mid-cycle → opcode=0000, valid=0, count=0, in_ready=0 immediately; after release, in_ready=1 and valid stays 0.
- Streaming: push 0001,0010,0011 on consecutive edges (stall=0) → opcode/valid 0001/1, 0010/1, 0011/1 on the three edges following each push, then 0000/0 and busy=0.
- Branch bubble (BUBBLES=2): queue 1000,0001 → 1000/1, then 0000/0, 0000/0, then 0001/1. Repeat with 1001 for identical timing; repeat with BUBBLES=0 for no gap.
- Full/backpressure (DEPTH=4): hold stall=1, offer 5 opcodes 0001..0101 → first 4 accepted, count=4, in_ready=0 with 0101 held. Release stall → 0001..0100 issue in order, then 0101 is accepted and issued.
- Stall in bubble: issue 1000, assert stall for 3 cycles during the first bubble → valid stays 0, counter frozen. After release, exactly BUBBLES−1 further bubble cycles occur before the next issue.
- Flush: queue 0110,0111,1010 with in_valid=1 carrying 1011 and flush=1 for one cycle → count=0, 1011 dropped, valid=0 next cycle, busy=0. A flush during BUBBLE also ends the bubble.

Source files
------------

// File: rtl/opcode_issue_sequencer.sv
// opcode_issue_sequencer
//   Instruction issue front-end. Opcodes from fetch are buffered in a small
//   FIFO and issued one per unstalled cycle on a registered opcode/valid pair.
//   A programmable number of bubble cycles (valid=0) follows every issued
//   BRANCH (1000) or JUMP (1001). Supports a downstream stall and a flush.
//
//   state  | meaning
//   -------+-------------------------------------------
//   IDLE   | FIFO empty, no bubble pending
//   ISSUE  | FIFO non-empty, head is issued next edge
//   BUBBLE | bubble counter > 0, issuing NOPs
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_opcode  opcode offered by fetch
//   in_valid   in_opcode is valid
//   in_ready   push accepted on an edge where in_valid && in_ready
//   stall      downstream hold; freezes issue state (pushes still accepted)
//   flush      discard queued opcodes and pending bubbles
//   opcode     registered opcode to the control unit
//   valid      registered valid to the control unit
//   count      FIFO occupancy
//   busy       FIFO non-empty or bubble in progress
module opcode_issue_sequencer #(
  parameter int DEPTH   = 4,
  parameter int BUBBLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 in_opcode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       stall,
  input  logic                       flush,
  output logic [3:0]                 opcode,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_BUBBLE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      bub_q, bub_d;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      mem [DEPTH];
  logic [3:0]      opcode_q, opcode_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            push, pop;
  logic            fifo_empty;
  logic [3:0]      head;
  logic            head_is_br;
  state_t          post_state;

  assign fifo_empty = (count_q == '0);
  assign head       = mem[rd_ptr_q];
  assign head_is_br = (head[3:1] == 3'b100);

  assign in_ready = (count_q < CW'(DEPTH)) && !flush && !rst;
  assign push     = in_valid && in_ready;
  // Pop is decided from registered state only, so the count can be resolved
  // before the next-state logic that depends on it.
  assign pop      = !flush && !stall && (state_q != S_BUBBLE) && !fifo_empty;

  assign count_d    = flush ? '0 : (count_q + CW'(push) - CW'(pop));
  assign post_state = (count_d != '0) ? S_ISSUE : S_IDLE;

  always_comb begin
    state_d  = state_q;
    bub_d    = bub_q;
    opcode_d = opcode_q;
    valid_d  = valid_q;
    if (flush) begin
      state_d  = S_IDLE;
      bub_d    = '0;
      opcode_d = 4'b0000;
      valid_d  = 1'b0;
    end else if (!stall) begin
      case (state_q)
        S_BUBBLE: begin
          opcode_d = 4'b0000;
          valid_d  = 1'b0;
          bub_d    = bub_q - 3'd1;
          // Last bubble cycle: the following edge may issue again.
          if (bub_q <= 3'd1) state_d = post_state;
        end
        default: begin
          if (!fifo_empty) begin
            opcode_d = head;
            valid_d  = 1'b1;
            if (head_is_br && (BUBBLES > 0)) begin
              bub_d   = 3'(BUBBLES);
              state_d = S_BUBBLE;
            end else begin
              state_d = post_state;
            end
          end else begin
            opcode_d = 4'b0000;
            valid_d  = 1'b0;
            state_d  = post_state;
          end
        end
      endcase
    end
  end

  assign busy_d = (count_d != '0) || (state_d == S_BUBBLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bub_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      opcode_q <= 4'b0000;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bub_q    <= bub_d;
      count_q  <= count_d;
      opcode_q <= opcode_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_opcode;
  end

  assign opcode = opcode_q;
  assign valid  = valid_q;
  assign count  = count_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_opcode_issue_sequencer.sv
module tb_opcode_issue_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_opcode;
  logic       in_valid;
  logic       stall;
  logic       flush;

  logic       in_ready_a, valid_a, busy_a;
  logic [3:0] opcode_a;
  logic [2:0] count_a;
  logic       in_ready_b, valid_b, busy_b;
  logic [3:0] opcode_b;
  logic [2:0] count_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  opcode_issue_sequencer #(.DEPTH(4), .BUBBLES(2)) dut_a (
    .clk(clk), .rst(rst), .in_opcode(in_opcode), .in_valid(in_valid),
    .in_ready(in_ready_a), .stall(stall), .flush(flush),
    .opcode(opcode_a), .valid(valid_a), .count(count_a), .busy(busy_a)
  );

  opcode_issue_sequencer #(.DEPTH(4), .BUBBLES(0)) dut_b (
    .clk(clk), .rst(rst), .in_opcode(in_opcode), .in_valid(in_valid),
    .in_ready(in_ready_b), .stall(stall), .flush(flush),
    .opcode(opcode_b), .valid(valid_b), .count(count_b), .busy(busy_b)
  );

  typedef struct {
    logic       rs;     // reset before this row
    logic       sel;    // 0: BUBBLES=2 instance, 1: BUBBLES=0 instance
    logic       iv;
    logic [3:0] op;
    logic       st;
    logic       fl;
    logic       e_rdy;  // in_ready before the edge
    logic       e_val;  // after the edge
    logic [3:0] e_op;
    logic [2:0] e_cnt;
    logic       e_busy;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb[$];

  function automatic vec_t mk(logic rs, logic sel, logic iv, logic [3:0] op,
                              logic st, logic fl, logic e_rdy, logic e_val,
                              logic [3:0] e_op, logic [2:0] e_cnt, logic e_busy);
    vec_t v;
    v.rs = rs; v.sel = sel; v.iv = iv; v.op = op; v.st = st; v.fl = fl;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_op = e_op; v.e_cnt = e_cnt;
    v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0d required=%0d", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_opcode = 4'h0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic run_row(input vec_t v, input int idx);
    logic       a_rdy, a_val, a_busy;
    logic [3:0] a_op;
    logic [2:0] a_cnt;
    logic [3:0] h;
    if (v.rs) do_reset();
    @(negedge clk);
    in_valid = v.iv; in_opcode = v.op; stall = v.st; flush = v.fl;
    #1;
    a_rdy = v.sel ? in_ready_b : in_ready_a;
    chk("in_ready", idx, a_rdy, v.e_rdy);
    @(posedge clk);
    #1;
    a_val  = v.sel ? valid_b  : valid_a;
    a_op   = v.sel ? opcode_b : opcode_a;
    a_cnt  = v.sel ? count_b  : count_a;
    a_busy = v.sel ? busy_b   : busy_a;
    chk("valid", idx, a_val, v.e_val);
    chk("opcode", idx, a_op, v.e_op);
    chk("count", idx, a_cnt, v.e_cnt);
    chk("busy", idx, a_busy, v.e_busy);
    if (v.fl) sb.delete();
    if (a_val) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", idx, 1, 0);
      end else begin
        h = sb.pop_front();
        chk("sb_order", idx, a_op, h);
      end
    end
    if (v.iv && v.e_rdy) sb.push_back(v.op);
  endtask

  initial begin
    // Streaming, including an opcode in the NOP range issued unmodified
    vecs.push_back(mk(1,0,1,4'h1,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,1,4'h2,0,0,1,1,4'h1,1,1));
    vecs.push_back(mk(0,0,1,4'h3,0,0,1,1,4'h2,1,1));
    vecs.push_back(mk(0,0,1,4'hF,0,0,1,1,4'h3,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,1,4'hF,0,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,0,4'h0,0,0));
    // Branch bubble, BUBBLES=2
    vecs.push_back(mk(1,0,1,4'h8,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,1,4'h1,0,0,1,1,4'h8,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,1,4'h1,0,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,0,4'h0,0,0));
    // Jump bubble, BUBBLES=2
    vecs.push_back(mk(1,0,1,4'h9,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,1,4'h1,0,0,1,1,4'h9,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,1,4'h1,0,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,0,4'h0,0,0));
    // Branch with BUBBLES=0: no gap
    vecs.push_back(mk(1,1,1,4'h8,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,1,1,4'h1,0,0,1,1,4'h8,1,1));
    vecs.push_back(mk(0,1,0,4'h0,0,0,1,1,4'h1,0,0));
    vecs.push_back(mk(0,1,0,4'h0,0,0,1,0,4'h0,0,0));
    // Full / backpressure under stall
    vecs.push_back(mk(1,0,1,4'h1,1,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,1,4'h2,1,0,1,0,4'h0,2,1));
    vecs.push_back(mk(0,0,1,4'h3,1,0,1,0,4'h0,3,1));
    vecs.push_back(mk(0,0,1,4'h4,1,0,1,0,4'h0,4,1));
    vecs.push_back(mk(0,0,1,4'h5,1,0,0,0,4'h0,4,1));
    vecs.push_back(mk(0,0,1,4'h5,0,0,0,1,4'h1,3,1));
    vecs.push_back(mk(0,0,1,4'h5,0,0,1,1,4'h2,3,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,1,4'h3,2,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,1,4'h4,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,1,4'h5,0,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,0,4'h0,0,0));
    // Stall during the first bubble cycle freezes the bubble counter
    vecs.push_back(mk(1,0,1,4'h8,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,1,4'h2,0,0,1,1,4'h8,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,0,4'h0,1,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,0,4'h0,1,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,0,4'h0,1,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,1,4'h2,0,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,0,4'h0,0,0));
    // Flush of a queued FIFO (with stall), then flush during a bubble
    vecs.push_back(mk(1,0,1,4'h6,1,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,1,4'h7,1,0,1,0,4'h0,2,1));
    vecs.push_back(mk(0,0,1,4'hA,1,0,1,0,4'h0,3,1));
    vecs.push_back(mk(0,0,1,4'hB,1,1,0,0,4'h0,0,0));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,0,4'h0,0,0));
    vecs.push_back(mk(0,0,1,4'h9,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,1,4'h3,0,0,1,1,4'h9,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,1,0,0,4'h0,0,0));
    vecs.push_back(mk(0,0,1,4'h4,0,0,1,0,4'h0,1,1));
    vecs.push_back(mk(0,0,0,4'h0,0,0,1,1,4'h4,0,0));

    // Reset state while rst is held
    rst = 1'b1;
    in_valid = 1'b0; in_opcode = 4'h0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_opcode", -1, opcode_a, 0);
    chk("rst_valid", -1, valid_a, 0);
    chk("rst_count", -1, count_a, 0);
    chk("rst_busy", -1, busy_a, 0);
    chk("rst_in_ready", -1, in_ready_a, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", -1, in_ready_a, 1);

    // Asynchronous reset mid-stream with three opcodes queued
    stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_opcode = 4'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_valid", -1, valid_a, 1);
    chk("pre_rst_opcode", -1, opcode_a, 1);
    chk("pre_rst_count", -1, count_a, 2);
    #1;
    rst = 1'b1;
    #1;
    chk("async_opcode", -1, opcode_a, 0);
    chk("async_valid", -1, valid_a, 0);
    chk("async_count", -1, count_a, 0);
    chk("async_busy", -1, busy_a, 0);
    chk("async_in_ready", -1, in_ready_a, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", -1, in_ready_a, 1);
    @(posedge clk);
    #1;
    chk("post_rst_valid", -1, valid_a, 0);
    chk("post_rst_count", -1, count_a, 0);

    foreach (vecs[i]) run_row(vecs[i], i);
    chk("sb_drained", -1, sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
